stall_dmem: RTL and testbench

Multicycle data-memory responder that serves the processor's memory stage. Accepts one read or write per request, holds `Stall` high for a fixed access latency, then returns `Done` with read data for one cycle. `Stall` feeds the pipeline-wide `Dmem_Stall` freeze, and the memory stage drives the request inputs.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_array.sv | 32 +++
 rtl/stall_dmem.sv | 123 ++++++++++++
 tb/tb_stall_dmem.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the stall_dmem multicycle data memory.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  // FSM encoding; 2'b11 is unreachable and flags an error if ever seen
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Default access latency, request acceptance to Done
  localparam int DMEM_LATENCY_DEFAULT = 4;

  // Latched operation kind
  localparam logic DMEM_OP_RD = 1'b0;
  localparam logic DMEM_OP_WR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Single-port 16-bit word array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_array #(
  parameter int WORDS_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORDS_LOG2-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  logic [15:0] mem [0:(2**WORDS_LOG2)-1];

  // Commit a write on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

`default_nettype wire

// File: rtl/stall_dmem.sv
// ---------------------------------------------------------------------------
// stall_dmem
// Multicycle data-memory responder for the memory stage. Accepts one read
// or write, holds Stall for LATENCY cycles, then pulses Done with data.
// Optional build macro: STALL_DMEM_ALIGN_CHECK_EN (odd Addr flags err).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stall_dmem
  import dmem_pkg::*;
#(
  parameter int LATENCY    = DMEM_LATENCY_DEFAULT,
  parameter int WORDS_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err
);

  // Reject latencies the 4-bit counter cannot express
  generate
    if ((LATENCY < 2) || (LATENCY > 15)) begin : g_latency_check
      $error("stall_dmem: LATENCY must be in 2..15");
    end
  endgenerate

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

  state_t                  state;
  logic [3:0]              cnt;
  logic [WORDS_LOG2-1:0]   addr_q;
  logic [15:0]             data_q;
  logic                    op_q;

  logic                    req_one;
  logic                    req_both;
  logic                    mem_we;
  logic [15:0]             rdata;

  assign req_one  = Rd ^ Wr;
  assign req_both = Rd & Wr;

  // The array is only written at the last BUSY cycle of a latched write
  assign mem_we = (state == ST_BUSY) && (cnt == 4'd0) && (op_q == DMEM_OP_WR);

  // Freeze the pipeline from the accepting cycle through the last BUSY cycle;
  // forced low while reset is asserted so a held request cannot leak through
  assign Stall = rst && (((state == ST_IDLE) && req_one) || (state == ST_BUSY));

  dmem_array #(
    .WORDS_LOG2 (WORDS_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (rdata)
  );

  // Control FSM, latency counter, request latches and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      data_q  <= 16'h0000;
      op_q    <= DMEM_OP_RD;
      DataOut <= 16'h0000;
      Done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_one) begin
            addr_q <= Addr[WORDS_LOG2:1];
            data_q <= DataIn;
            op_q   <= Wr ? DMEM_OP_WR : DMEM_OP_RD;
            cnt    <= CNT_LOAD;
            state  <= ST_BUSY;
`ifdef STALL_DMEM_ALIGN_CHECK_EN
            // Odd byte address is flagged, but the word access still runs
            if (Addr[0]) begin
              err <= 1'b1;
            end
`endif
          end else if (req_both) begin
            err <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt == 4'd0) begin
            if (op_q == DMEM_OP_RD) begin
              DataOut <= rdata;
            end
            Done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          err   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stall_dmem.sv
// ---------------------------------------------------------------------------
// tb_stall_dmem
// Directed self-checking bench for stall_dmem (LATENCY=4, WORDS_LOG2=10).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stall_dmem;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  stall_dmem #(
    .LATENCY    (LAT),
    .WORDS_LOG2 (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .Rd      (Rd),
    .Wr      (Wr),
    .DataOut (DataOut),
    .Done    (Done),
    .Stall   (Stall),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full access starting in IDLE; checks Stall window, Done pulse, data
  task automatic access(input string tag, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input logic chkq, input logic [15:0] expq);
    Rd     = ~wr;
    Wr     = wr;
    Addr   = a;
    DataIn = d;
    #1;
    check({tag, "_stall_accept"}, {15'd0, Stall}, 16'd1);
    tick();
    Rd = 1'b0;
    Wr = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      check({tag, "_stall_busy"}, {15'd0, Stall}, 16'd1);
      check({tag, "_done_busy"}, {15'd0, Done}, 16'd0);
      tick();
    end
    check({tag, "_done"}, {15'd0, Done}, 16'd1);
    check({tag, "_stall_done"}, {15'd0, Stall}, 16'd0);
    if (chkq) check({tag, "_data"}, DataOut, expq);
    tick();
    check({tag, "_done_clear"}, {15'd0, Done}, 16'd0);
  endtask

  initial begin
    // Reset with a pending write request: nothing may escape
    rst    = 1'b0;
    Rd     = 1'b0;
    Wr     = 1'b1;
    Addr   = 16'h0010;
    DataIn = 16'hBEEF;
    tick();
    tick();
    check("rst_stall",   {15'd0, Stall}, 16'd0);
    check("rst_done",    {15'd0, Done},  16'd0);
    check("rst_dataout", DataOut,        16'h0000);
    check("rst_err",     {15'd0, err},   16'd0);

    // Release; held request accepted at the first edge
    rst = 1'b1;
    access("wr_beef", 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000);
    access("rd_beef", 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF);

    // Aliasing: 0x0808 maps to the same word as 0x0008
    access("wr_a5",   1'b1, 16'h0008, 16'hA5A5, 1'b0, 16'h0000);
    access("rd_alias",1'b0, 16'h0808, 16'h0000, 1'b1, 16'hA5A5);

    // Collision: err sticky, no stall, no access
    access("wr_5555", 1'b1, 16'h0030, 16'h5555, 1'b0, 16'h0000);
    Rd     = 1'b1;
    Wr     = 1'b1;
    Addr   = 16'h0030;
    DataIn = 16'hFFFF;
    #1;
    check("coll_stall0", {15'd0, Stall}, 16'd0);
    check("coll_err0",   {15'd0, err},   16'd0);
    tick();
    check("coll_err1",   {15'd0, err},   16'd1);
    check("coll_stall1", {15'd0, Stall}, 16'd0);
    Rd = 1'b0;
    Wr = 1'b0;
    tick();
    check("coll_done",   {15'd0, Done},  16'd0);
    access("rd_coll", 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h5555);
    check("coll_sticky", {15'd0, err},   16'd1);

    // Reset clears err and DataOut
    rst = 1'b0;
    #1;
    check("rst2_err",     {15'd0, err}, 16'd0);
    check("rst2_dataout", DataOut,      16'h0000);
    tick();
    rst = 1'b1;
    tick();

    // Mid-write reset: old contents survive
    access("wr_7777", 1'b1, 16'h0040, 16'h7777, 1'b0, 16'h0000);
    Wr     = 1'b1;
    Addr   = 16'h0040;
    DataIn = 16'h1234;
    #1;
    check("mw_stall_t",  {15'd0, Stall}, 16'd1);
    tick();
    Wr = 1'b0;
    check("mw_stall_b1", {15'd0, Stall}, 16'd1);
    tick();
    rst = 1'b0;
    #1;
    check("mw_rst_stall", {15'd0, Stall}, 16'd0);
    check("mw_rst_done",  {15'd0, Done},  16'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mw_idle_stall", {15'd0, Stall}, 16'd0);
    tick();
    check("mw_idle_done",  {15'd0, Done},  16'd0);
    access("rd_mw", 1'b0, 16'h0040, 16'h0000, 1'b1, 16'h7777);

    // DataOut holds across a write
    access("wr_0101", 1'b1, 16'h0050, 16'h0101, 1'b0, 16'h0000);
    check("hold_dataout", DataOut, 16'h7777);
    access("rd_0101", 1'b0, 16'h0050, 16'h0000, 1'b1, 16'h0101);

    // Odd address: word 0x0010; err only when alignment checking is built in
    check("align_err_pre", {15'd0, err}, 16'd0);
    access("rd_odd", 1'b0, 16'h0011, 16'h0000, 1'b1, 16'hBEEF);
`ifdef STALL_DMEM_ALIGN_CHECK_EN
    check("align_err", {15'd0, err}, 16'd1);
`else
    check("align_err", {15'd0, err}, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
